// File: rtl/data_mem.sv
// data_mem: single-port word memory behind a valid/ready request channel with a
// fixed-latency, held response. Writes commit on the accept edge with byte strobes.
// Optional build macro: DATA_MEM_MISALIGN_ERR_EN (misaligned requests return an error).
module data_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned IW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW   = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int unsigned LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    mem [DEPTH_WORDS];
  logic [31:0]    rdata_q;
  logic           err_q;

  logic [29:0]    word_off;
  logic [IW-1:0]  idx;
  logic           range_err;
  logic           misalign_err;
  logic           acc_err;
  logic           accept;

  // BASE_ADDR is word aligned, so subtracting on bits [31:2] equals the byte
  // subtraction shifted right by two, and leaves addr[1:0] free for the alignment check.
  assign word_off  = req_addr_i[31:2] - BASE_ADDR[31:2];
  assign idx       = word_off[IW-1:0];
  assign range_err = (req_addr_i < BASE_ADDR) || ({2'b00, word_off} >= 32'(DEPTH_WORDS));

`ifdef DATA_MEM_MISALIGN_ERR_EN
  assign misalign_err = |req_addr_i[1:0];
`else
  assign misalign_err = 1'b0;
`endif

  assign acc_err     = range_err || misalign_err;
  assign req_ready_o = !reset_i && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready_i));
  assign accept      = req_valid_i && req_ready_o;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  // Next-state logic: accept launches a response, WAIT counts down, RESP holds until taken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LOAD);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          if (accept) begin
            if (LATENCY == 1) begin
              state_d = RESP;
            end else begin
              state_d = WAIT;
              cnt_d   = CW'(LOAD);
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and latency counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Byte-strobed write on the accept edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && req_we_i && !acc_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (req_wstrb_i[b]) begin
          mem[idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Response payload captured on accept and held until the next accept.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      err_q   <= acc_err;
      rdata_q <= (req_we_i || acc_err) ? '0 : mem[idx];
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed vectors for data_mem. Instance 0 uses LATENCY=1, base 0;
// instance 1 uses LATENCY=3, base 0x100. Both have 16 words.
module tb_data_mem;

`ifdef DATA_MEM_MISALIGN_ERR_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        req_we    [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_mem #(.DEPTH_WORDS(16), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) u_l1 (
    .clk_i(clk), .reset_i(rst[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_addr_i(req_addr[0]),
    .req_we_i(req_we[0]), .req_wdata_i(req_wdata[0]), .req_wstrb_i(req_wstrb[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
  );

  data_mem #(.DEPTH_WORDS(16), .LATENCY(3), .BASE_ADDR(32'h0000_0100)) u_l3 (
    .clk_i(clk), .reset_i(rst[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_addr_i(req_addr[1]),
    .req_we_i(req_we[1]), .req_wdata_i(req_wdata[1]), .req_wstrb_i(req_wstrb[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t        vecs [14];
  logic [31:0] mdl  [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One request on instance s with response ready held high; reports response and latency.
  task automatic xact(input int s, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      output logic err, output logic [31:0] rdata, output int lat);
    @(negedge clk);
    req_valid[s] = 1'b1;
    req_we[s]    = we;
    req_addr[s]  = addr;
    req_wdata[s] = wdata;
    req_wstrb[s] = strb;
    rsp_ready[s] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[s] = 1'b0;
    req_we[s]    = 1'b0;
    lat   = 0;
    err   = 1'b1;
    rdata = '1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid[s]) begin
        lat   = i;
        err   = rsp_err[s];
        rdata = rsp_rdata[s];
        break;
      end
    end
  endtask

  logic        e;
  logic [31:0] d;
  int          lat;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = '0;
      req_wdata[s] = '0; req_wstrb[s] = '0; rsp_ready[s] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_ready%0d", s), 32'(req_ready[s]), 32'd0);
      chk($sformatf("rst_valid%0d", s), 32'(rsp_valid[s]), 32'd0);
      chk($sformatf("rst_rdata%0d", s), rsp_rdata[s], 32'd0);
      chk($sformatf("rst_err%0d", s), 32'(rsp_err[s]), 32'd0);
      rst[s] = 1'b0;
    end
    #1;
    chk("ready_after_rst0", 32'(req_ready[0]), 32'd1);
    chk("ready_after_rst1", 32'(req_ready[1]), 32'd1);

    // Fill instance 0 with a known pattern.
    for (int i = 0; i < 16; i++) begin
      mdl[i] = 32'hA5A5_0000 + 32'(i);
      xact(0, 1'b1, 32'(i * 4), mdl[i], 4'hF, e, d, lat);
      chk($sformatf("fill_err%0d", i), 32'(e), 32'd0);
      chk($sformatf("fill_lat%0d", i), 32'(lat), 32'd1);
    end

    vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h20,       32'h11223344, 4'hF, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h20,       32'h0,        4'h0, 1'b0, 32'h11BB33DD};
    vecs[5]  = '{1'b1, 32'h24,       32'hFFFFFFFF, 4'h0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h24,       32'h0,        4'h0, 1'b0, 32'hA5A50009};
    vecs[7]  = '{1'b0, 32'h40,       32'h0,        4'h0, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 32'h40,       32'h12345678, 4'hF, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 32'h3C,       32'h0,        4'h0, 1'b0, 32'hA5A5000F};
    vecs[10] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 1'b1, 32'h0};
    vecs[11] = '{1'b1, 32'h13,       32'h00000055, 4'hF, MIS,  32'h0};
    vecs[12] = '{1'b0, 32'h10,       32'h0,        4'h0, 1'b0, MIS ? 32'hDEADBEEF : 32'h00000055};
    vecs[13] = '{1'b0, 32'h3E,       32'h0,        4'h0, MIS,  MIS ? 32'h0 : 32'hA5A5000F};

    for (int v = 0; v < 14; v++) begin
      xact(0, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].strb, e, d, lat);
      chk($sformatf("vec%0d_err", v), 32'(e), 32'(vecs[v].err));
      chk($sformatf("vec%0d_rdata", v), d, vecs[v].rdata);
      chk($sformatf("vec%0d_lat", v), 32'(lat), 32'd1);
      if (vecs[v].we && !vecs[v].err) begin
        for (int b = 0; b < 4; b++) begin
          if (vecs[v].strb[b]) mdl[vecs[v].addr[5:2]][8*b +: 8] = vecs[v].wdata[8*b +: 8];
        end
      end
    end

    // Every word matches the model (out-of-range write touched nothing).
    for (int i = 0; i < 16; i++) begin
      xact(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, e, d, lat);
      chk($sformatf("sweep%0d", i), d, mdl[i]);
    end

    // Back-to-back write then read of the same word, one accept per cycle.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h4;
    req_wdata[0] = 32'h1; req_wstrb[0] = 4'hF; rsp_ready[0] = 1'b1;
    #1 chk("b2b_ready0", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    chk("b2b_wvalid", 32'(rsp_valid[0]), 32'd1);
    chk("b2b_werr", 32'(rsp_err[0]), 32'd0);
    req_we[0] = 1'b0;
    #1 chk("b2b_ready1", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    chk("b2b_rvalid", 32'(rsp_valid[0]), 32'd1);
    chk("b2b_rdata", rsp_rdata[0], 32'h1);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("b2b_idle", 32'(rsp_valid[0]), 32'd0);

    // LATENCY=3 instance basics.
    xact(1, 1'b1, 32'h100, 32'hCAFEF00D, 4'hF, e, d, lat);
    chk("l3_w0_err", 32'(e), 32'd0);
    chk("l3_w0_lat", 32'(lat), 32'd3);
    xact(1, 1'b1, 32'h104, 32'h00104104, 4'hF, e, d, lat);
    chk("l3_w1_err", 32'(e), 32'd0);
    xact(1, 1'b0, 32'h0FC, 32'h0, 4'h0, e, d, lat);
    chk("l3_below_err", 32'(e), 32'd1);
    chk("l3_below_rdata", d, 32'h0);
    xact(1, 1'b0, 32'h140, 32'h0, 4'h0, e, d, lat);
    chk("l3_above_err", 32'(e), 32'd1);

    // Stalled response: ready low for 5 response cycles, request inputs ignored meanwhile.
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h100; rsp_ready[1] = 1'b0;
    @(posedge clk);
    #1;
    req_we[1] = 1'b1; req_wdata[1] = 32'hFFFFFFFF; req_wstrb[1] = 4'hF;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("stall_valid_k%0d", k), 32'(rsp_valid[1]), (k >= 3) ? 32'd1 : 32'd0);
      chk($sformatf("stall_ready_k%0d", k), 32'(req_ready[1]), 32'd0);
      if (k >= 3) begin
        chk($sformatf("stall_rdata_k%0d", k), rsp_rdata[1], 32'hCAFEF00D);
        chk($sformatf("stall_err_k%0d", k), 32'(rsp_err[1]), 32'd0);
      end
    end
    req_valid[1] = 1'b0; req_we[1] = 1'b0; rsp_ready[1] = 1'b1;
    #1 chk("stall_ready_comb", 32'(req_ready[1]), 32'd1);
    @(negedge clk);
    chk("stall_done_valid", 32'(rsp_valid[1]), 32'd0);
    chk("stall_done_ready", 32'(req_ready[1]), 32'd1);
    xact(1, 1'b0, 32'h100, 32'h0, 4'h0, e, d, lat);
    chk("stall_ignored_write", d, 32'hCAFEF00D);

    // Write presented during reset is dropped.
    @(negedge clk);
    rst[1] = 1'b1; req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h104;
    req_wdata[1] = 32'hBAD0BAD0; req_wstrb[1] = 4'hF;
    #1 chk("rst_wr_ready", 32'(req_ready[1]), 32'd0);
    @(negedge clk);
    rst[1] = 1'b0; req_valid[1] = 1'b0; req_we[1] = 1'b0;
    xact(1, 1'b0, 32'h104, 32'h0, 4'h0, e, d, lat);
    chk("rst_wr_dropped", d, 32'h00104104);

    // Reset while a read is in WAIT: the response is never issued.
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h100; rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("wait_rst_pre", 32'(rsp_valid[1]), 32'd0);
    rst[1] = 1'b1;
    @(negedge clk);
    chk("wait_rst_valid", 32'(rsp_valid[1]), 32'd0);
    chk("wait_rst_ready", 32'(req_ready[1]), 32'd0);
    rst[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("wait_rst_quiet%0d", k), 32'(rsp_valid[1]), 32'd0);
    end
    xact(1, 1'b0, 32'h104, 32'h0, 4'h0, e, d, lat);
    chk("post_rst_rdata", d, 32'h00104104);
    chk("post_rst_lat", 32'(lat), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem.md
# data_mem

On-chip word memory directly downstream of the core datapath's memory ports, serving both instruction fetches and data loads/stores. It accepts one request at a time over a valid/ready handshake, commits writes with per-byte strobes, and returns a response after a fixed, parameterised latency. The response is held until the consumer takes it, so the datapath can stall cleanly on memory.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, at least 2.
- LATENCY, 1: cycles from request acceptance to the first cycle of `rsp_valid_o`; at least 1.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request can be accepted this cycle.
- req_addr_i  in  32  byte address.
- req_we_i  in  1  1 = write, 0 = read.
- req_wdata_i  in  32  write data.
- req_wstrb_i  in  4  byte enables; bit n enables byte lane n (bits 8n+7:8n).
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer takes the response.
- rsp_rdata_o  out  32  read data; 0 for writes and for errors.
- rsp_err_o  out  1  access was out of range, or misaligned (see Configuration).

## Operation
- Accept: a request is accepted on an edge where `req_valid_i && req_ready_o`. Address, direction and data are latched on that edge.
- Range check: the word index is `(req_addr_i - BASE_ADDR) >> 2`, computed in 32 bits. The access is out of range if the index is at least DEPTH_WORDS or if `req_addr_i < BASE_ADDR`.
- Write: committed on the accept edge only if the access is in range and not flagged as an error. Only the strobed lanes change. `req_wstrb_i = 0` is a legal no-op and gets a normal response.
- Read: the word is sampled on the accept edge.
  - A read accepted the cycle after a write to the same word returns the new data.
  - A single accept cannot be both a read and a write.
- Error: no write occurs. The response has `rsp_err_o = 1` and `rsp_rdata_o = 0`.
- States:
  - IDLE: `req_ready_o = 1`. On accept, go to RESP if LATENCY = 1; otherwise load the counter with LATENCY-2 and go to WAIT.
  - WAIT: `req_ready_o = 0`. Decrement the counter; at 0, go to RESP.
  - RESP: `rsp_valid_o = 1`, and `rsp_rdata_o`/`rsp_err_o` stay stable until the handshake.
    - `req_ready_o = rsp_ready_i` (combinational).
    - On `rsp_ready_i` with no new accept, go to IDLE.
    - On `rsp_ready_i` with a new accept (back-to-back), take the same path as an accept from IDLE.
- Memory contents are not initialised and not affected by reset.

## Timing
- Reset values: state IDLE, counter 0, `rsp_valid_o = 0`, `rsp_rdata_o = 0`, `rsp_err_o = 0`. `req_ready_o` is 0 during the reset cycle and 1 in the first cycle after reset.
- Reset has priority over everything else. An accept in the same cycle as `reset_i` is dropped and performs no write.
- Reset mid-operation drops the pending response. A write already committed on its accept edge remains in memory.
- Latency:
  - `rsp_valid_o` rises LATENCY cycles after the accept edge.
  - Back-to-back throughput is one request per LATENCY cycles when `rsp_ready_i` is held at 1.
  - With LATENCY = 1 and continuous ready, throughput is one request per cycle.
- `rsp_valid_o` never drops without a handshake except on reset.
- Request inputs are ignored while `req_ready_o = 0`.

## Configuration
- DATA_MEM_MISALIGN_ERR_EN defined: a request with `req_addr_i[1:0] != 0` produces an error response and no write, for both reads and writes.
- DATA_MEM_MISALIGN_ERR_EN undefined: `req_addr_i[1:0]` is ignored, so the access goes to the containing word, and misalignment never raises `rsp_err_o`.

## Test plan
- Reset, then write 0xDEADBEEF to 0x10 with strobe 0xF, then read 0x10 with LATENCY = 1 → the read response arrives one cycle after accept with rdata 0xDEADBEEF and err 0.
- Word 0x20 holds 0x11223344; write 0xAABBCCDD with strobe 0b0101, then read 0x20 → 0x11BB33DD.
- Read address BASE_ADDR + DEPTH_WORDS*4 → err 1, rdata 0. Write to the same address → err 1, and all memory words are unchanged.
- LATENCY = 3 with `rsp_ready_i` held 0 for 5 cycles → `rsp_valid_o` rises 3 cycles after accept, data stays stable while held, `req_ready_o = 0` throughout, and the handshake completes when ready goes high.
- Write 0x1 to 0x4, then read 0x4 accepted in the following cycle with LATENCY = 1 and continuous ready → one accept per cycle and read data 0x1. Assert `reset_i` while a LATENCY = 3 read is in WAIT → `rsp_valid_o = 0` next cycle and no response is ever issued.
- With DATA_MEM_MISALIGN_ERR_EN defined, write 0x55 to 0x13 → err 1, and word 0x10 is unchanged. Without the macro, the same write updates word 0x10 and err is 0.
